// File: rtl/ws2812_pkg.sv
// Shared types and defaults for the WS2812 frame scheduler.
// Holds the frame-loop state encoding and the latch-gap helper.
package ws2812_pkg;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 24;
  localparam int DEF_MIN_LATCH = 2500;

  typedef enum logic [1:0] {IDLE, LATCH, STREAM, DRAIN} state_t;

  // Inter-frame gap never drops below the WS2812 latch time.
  function automatic logic [15:0] gap_len(input logic [15:0] delay, input logic [15:0] min_gap);
    return (delay > min_gap) ? delay : min_gap;
  endfunction

endpackage

// File: rtl/ws2812_mem_arbiter.sv
// Fixed-priority mux for the single-port pixel BRAM: reader first, writer otherwise.
// Out-of-range writes are still granted but dropped, with wr_err pulsed.
module ws2812_mem_arbiter #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
) (
  input  logic              enable,
  input  logic              rd_need,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              wr_err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  always_comb begin
    wr_gnt    = 1'b0;
    wr_err    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rd_need) begin
      mem_re   = 1'b1;
      mem_addr = rd_addr;
    end else if (wr_req && enable) begin
      wr_gnt = 1'b1;
      if (wr_addr < ADDR_W'(DEPTH)) begin
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end else begin
        wr_err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Frame loop (latch gap, fetch/stream pixels, drain) for a WS2812 chain,
// sharing the pixel BRAM with the UART writer; config is shadowed until frame start.
module ws2812_frame_scheduler
  import ws2812_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MIN_LATCH = DEF_MIN_LATCH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [ADDR_W-1:0] num_leds,
  input  logic [15:0]       data_delay,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              wr_err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              px_valid,
  output logic [DATA_W-1:0] px_data,
  output logic              px_last,
  input  logic              px_ready,
  input  logic              ser_busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [15:0]       MIN_GAP = 16'(MIN_LATCH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] shadow_n, act_n, fetch_idx, out_idx;
  logic [15:0]       shadow_d, act_d, gap_cnt;
  logic              hold_vld, rd_pend, rd_need, xfer, wr_en;
  logic [DATA_W-1:0] hold_dat;

  // A read is only issued into an empty hold register, so one pixel costs at most one port cycle.
  assign rd_need  = (state == STREAM) && !hold_vld && !rd_pend && (fetch_idx < act_n);
  assign px_valid = hold_vld;
  assign px_data  = hold_dat;
  assign px_last  = hold_vld && (out_idx == act_n - ADDR_W'(1));
  assign xfer     = hold_vld && px_ready;
  assign busy     = (state != IDLE);
  assign wr_en    = !reset;

  ws2812_mem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_arb (
    .enable    (wr_en),
    .rd_need   (rd_need),
    .rd_addr   (fetch_idx),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .wr_err    (wr_err),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:   if (cfg_valid && num_leds != '0) state_nxt = LATCH;
      LATCH:  if (gap_cnt == '0) state_nxt = (shadow_n == '0) ? IDLE : STREAM;
      STREAM: if (xfer && px_last) state_nxt = DRAIN;
      DRAIN: begin
        if (!ser_busy) begin
          frame_done = 1'b1;
          state_nxt  = LATCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // gap_cnt is loaded with gap-1 so LATCH lasts exactly the gap length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_n  <= '0;
      shadow_d  <= '0;
      act_n     <= '0;
      act_d     <= '0;
      gap_cnt   <= '0;
      fetch_idx <= '0;
      out_idx   <= '0;
      frame_cnt <= '0;
      rd_pend   <= 1'b0;
      hold_vld  <= 1'b0;
      hold_dat  <= '0;
    end else begin
      if (cfg_valid) begin
        shadow_n <= (num_leds > DEPTH_A) ? DEPTH_A : num_leds;
        shadow_d <= data_delay;
      end
      case (state)
        IDLE: begin
          if (cfg_valid && num_leds != '0) begin
            gap_cnt <= gap_len(data_delay, MIN_GAP) - 16'd1;
            act_d   <= data_delay;
          end
        end
        LATCH: begin
          if (gap_cnt == '0) begin
            act_n     <= shadow_n;
            act_d     <= shadow_d;
            fetch_idx <= '0;
            out_idx   <= '0;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        STREAM: begin
          if (rd_need) fetch_idx <= fetch_idx + ADDR_W'(1);
          if (xfer)    out_idx   <= out_idx + ADDR_W'(1);
        end
        DRAIN: begin
          if (!ser_busy) begin
            frame_cnt <= frame_cnt + 16'd1;
            gap_cnt   <= gap_len(act_d, MIN_GAP) - 16'd1;
          end
        end
        default: ;
      endcase
      rd_pend <= rd_need;
      if (rd_pend) begin
        hold_vld <= 1'b1;
        hold_dat <= mem_rdata;
      end else if (xfer) begin
        hold_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Directed-sequence bench with random pixel data; a BRAM model feeds the DUT and
// expected frames, gaps and write landings come from the bench's own pixel image.
module tb_ws2812_frame_scheduler;

  localparam int DEPTH = 1024;
  localparam int AW    = 16;
  localparam int DW    = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic [AW-1:0] num_leds;
  logic [15:0]   data_delay;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt, wr_err, mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          px_valid, px_last, px_ready, ser_busy, frame_done, busy;
  logic [DW-1:0] px_data;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  ws2812_frame_scheduler dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .num_leds(num_leds),
    .data_delay(data_delay), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .wr_err(wr_err), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .px_valid(px_valid), .px_data(px_data), .px_last(px_last), .px_ready(px_ready),
    .ser_busy(ser_busy), .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  logic [DW-1:0] bram    [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= '0;
    end else begin
      if (mem_we) bram[mem_addr[9:0]] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= bram[mem_addr[9:0]];
  end

  int checks = 0, passed = 0;
  int cyc_n = 0, cfg_cyc = 0;
  int both_cnt = 0, gnt_bad = 0, err_bad = 0, unstable = 0, wr_done = 0;
  int re_q[$], re_addr_q[$], xf_q[$], fd_q[$], last_q[$];
  logic [DW-1:0] got_q[$];
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_dat = '0;
  int k, fdc, mism, re0, w0, wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
  endtask

  // One clock: observe mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (cfg_valid) cfg_cyc = cyc_n;
    if (mem_re && mem_we) both_cnt++;
    if (wr_gnt !== (wr_req && !mem_re)) gnt_bad++;
    if (wr_err && !(wr_gnt && wr_addr >= AW'(DEPTH))) err_bad++;
    if (mem_re) begin
      re_q.push_back(cyc_n);
      re_addr_q.push_back(int'(mem_addr));
    end
    if (wr_gnt) begin
      wr_done++;
      if (wr_addr < AW'(DEPTH)) ref_mem[wr_addr[9:0]] = wr_data;
    end
    if (px_valid && px_ready) begin
      xf_q.push_back(cyc_n);
      got_q.push_back(px_data);
      if (px_last) last_q.push_back(got_q.size() - 1);
    end
    if (px_valid && !px_ready && stall_prev && px_data !== stall_dat) unstable++;
    stall_prev = px_valid && !px_ready;
    stall_dat  = px_data;
    if (frame_done) fd_q.push_back(cyc_n);
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    re_q.delete(); re_addr_q.delete(); xf_q.delete(); fd_q.delete();
    last_q.delete(); got_q.delete();
    unstable = 0;
  endtask

  task automatic cfg(input int n, input int d);
    cfg_valid  = 1'b1;
    num_leds   = AW'(n);
    data_delay = 16'(d);
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    int n0, t;
    n0 = wr_done; t = 0;
    wr_req = 1'b1; wr_addr = AW'(a); wr_data = d;
    while (wr_done == n0 && t < 8) begin tick(); t++; end
    wr_req = 1'b0;
    chk("write_grant", 32'(wr_done - n0), 1);
  endtask

  task automatic wait_fd(input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (fd_q.size() < n && t < budget) begin tick(); t++; end
    chk({tag, "_frame_done_seen"}, 32'(fd_q.size() >= n), 1);
  endtask

  task automatic wait_re(input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (re_q.size() < n && t < budget) begin tick(); t++; end
    chk({tag, "_read_seen"}, 32'(re_q.size() >= n), 1);
  endtask

  // Gap measured from the frame_done cycle to the next frame's first read.
  task automatic gap_check(input string tag, input int nfd, input int want_gap);
    int f;
    clr();
    wait_fd(nfd, 16000, tag);
    f = (fd_q.size() >= nfd) ? fd_q[nfd-1] : 0;
    clr();
    wait_re(1, 6000, tag);
    chk(tag, 32'(re_q[0] - f), 32'(want_gap + 1));
  endtask

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; num_leds = '0; data_delay = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; px_ready = 1'b1; ser_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_px_valid", 32'(px_valid), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_strobes", 32'({mem_we, mem_re, wr_gnt, wr_err, frame_done, px_last}), 0);
    chk("rst_px_data", 32'(px_data), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) wr(i, DW'($urandom));

    // Basic frame loop: 3 LEDs, short delay -> minimum gap
    clr();
    cfg(3, 10);
    wait_fd(2, 8000, "A");
    chk("A_first_gap", 32'(re_q[0] - cfg_cyc), 2501);
    chk("A_read_to_xfer", 32'(xf_q[0] - re_q[0]), 2);
    chk("A_read_pace", 32'(re_q[1] - re_q[0]), 3);
    chk("A_npix", 32'(got_q.size()), 6);
    for (int i = 0; i < 6; i++) chk("A_pixel", got_q[i], ref_mem[i % 3]);
    for (int i = 0; i < 3; i++) chk("A_read_addr", 32'(re_addr_q[i]), 32'(i));
    chk("A_last_count", 32'(last_q.size()), 2);
    chk("A_last0", 32'(last_q[0]), 2);
    chk("A_last1", 32'(last_q[1]), 5);
    chk("A_drain", 32'(fd_q[0] - xf_q[2]), 1);
    chk("A_gap_between", 32'(re_q[3] - fd_q[0]), 2501);
    chk("A_frame_cnt", 32'(frame_cnt), 2);

    // Requested delay above and below the minimum
    cfg(3, 4000);
    gap_check("B_gap4000", 1, 4000);
    cfg(3, 100);
    gap_check("B_gap100", 2, 2500);

    // Writer held continuously while streaming
    re0 = re_q.size(); w0 = wr_done; both_cnt = 0; gnt_bad = 0;
    wr_req = 1'b1; wr_addr = 16'd200; wr_data = DW'($urandom);
    repeat (12) begin
      wd = wr_done;
      tick();
      if (wr_done != wd) begin wr_addr = wr_addr + 16'd1; wr_data = DW'($urandom); end
    end
    wr_req = 1'b0;
    chk("C_reads_in_window", 32'(re_q.size() - re0), 2);
    chk("C_grants", 32'(wr_done - w0), 10);
    chk("C_gnt_vs_re", 32'(gnt_bad), 0);
    chk("C_we_re_exclusive", 32'(both_cnt), 0);
    mism = 0;
    for (int i = 0; i < wr_done - w0; i++) if (bram[200 + i] !== ref_mem[200 + i]) mism++;
    chk("C_writes_landed", 32'(mism), 0);

    // Serializer backpressure, then ser_busy holding off frame_done
    wait_fd(1, 100, "D_pre");
    px_ready = 1'b0;
    clr();
    wait_re(1, 3000, "D");
    repeat (500) tick();
    chk("D_reads_during_stall", 32'(re_q.size()), 1);
    chk("D_no_xfer", 32'(xf_q.size()), 0);
    chk("D_valid_held", 32'(px_valid), 1);
    chk("D_data_stable", 32'(unstable), 0);
    px_ready = 1'b1; ser_busy = 1'b1;
    k = 0;
    while (xf_q.size() < 3 && k < 50) begin tick(); k++; end
    chk("D_nxfer", 32'(xf_q.size()), 3);
    repeat (200) tick();
    chk("D_no_done_while_busy", 32'(fd_q.size()), 0);
    ser_busy = 1'b0;
    wait_fd(1, 10, "D");
    chk("D_drain_delay", 32'(fd_q[0] - xf_q[2]), 201);
    for (int i = 0; i < 3; i++) chk("D_order", got_q[i], ref_mem[i]);

    // Reconfiguration mid-frame takes effect on the next frame
    clr();
    wait_re(1, 3000, "E");
    cfg(5, 10);
    wait_fd(2, 8000, "E");
    chk("E_npix", 32'(got_q.size()), 8);
    chk("E_last0", 32'(last_q[0]), 2);
    chk("E_last1", 32'(last_q[1]), 7);
    mism = 0;
    for (int i = 0; i < 8; i++) if (got_q[i] !== ref_mem[(i < 3) ? i : i - 3]) mism++;
    chk("E_pixels", 32'(mism), 0);
    clr();
    cfg(0, 10);
    k = 0;
    while (busy && k < 3000) begin tick(); k++; end
    chk("E_idle_after_gap", 32'(busy), 0);
    chk("E_no_reads", 32'(re_q.size()), 0);
    cfg(0, 10);
    repeat (5) tick();
    chk("E_stay_idle", 32'(busy), 0);

    // Out-of-range write and oversized frame
    wr_req = 1'b1; wr_addr = AW'(DEPTH); wr_data = DW'($urandom);
    #1;
    chk("F_oob_gnt", 32'(wr_gnt), 1);
    chk("F_oob_err", 32'(wr_err), 1);
    chk("F_oob_no_we", 32'(mem_we), 0);
    tick();
    wr_req = 1'b0;
    clr();
    cfg(DEPTH + 7, 10);
    wait_fd(1, 7000, "F");
    chk("F_npix", 32'(got_q.size()), 32'(DEPTH));
    chk("F_last_count", 32'(last_q.size()), 1);
    chk("F_last_idx", 32'(last_q[0]), 32'(DEPTH - 1));
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (got_q[i] !== ref_mem[i]) mism++;
    chk("F_pixels", 32'(mism), 0);
    chk("F_err_spurious", 32'(err_bad), 0);
    chk("F_gnt_vs_re", 32'(gnt_bad), 0);

    // Asynchronous reset in the middle of streaming
    clr();
    wait_re(1, 3000, "R");
    repeat (2) tick();
    wr_req = 1'b1; wr_addr = 16'd5;
    reset = 1'b1;
    #1;
    chk("R_busy", 32'(busy), 0);
    chk("R_strobes", 32'({px_valid, px_last, mem_we, mem_re, wr_gnt, wr_err, frame_done}), 0);
    chk("R_px_data", 32'(px_data), 0);
    chk("R_frame_cnt", 32'(frame_cnt), 0);
    chk("R_mem_addr", 32'(mem_addr), 0);
    wr_req = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("R_stays_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
